midi_tx: RTL and testbench

MIDI_TX -- requirements
Module: midi_tx

---
 rtl/midi_pkg.sv | 30 +++
 rtl/midi_tx_if.sv | 12 +
 rtl/midi_fifo.sv | 75 +++++++
 rtl/midi_tx_wb.sv | 41 ++++
 rtl/midi_tx.sv | 190 +++++++++++++++++++
 tb/tb_midi_tx.sv | 258 +++++++++++++++++++++++++
 6 files changed

// File: rtl/midi_pkg.sv
// Shared definitions for the MIDI transmit/receive blocks: FSM states,
// register offsets, STATUS bit positions and the count-saturation helper.
package midi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } midi_state_e;

  localparam logic REG_STATUS = 1'b0;
  localparam logic REG_TXDATA = 1'b1;

  localparam int STAT_EMPTY   = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_BUSY    = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 4;

  // The STATUS count field is only four bits wide, so a 16-entry FIFO tops out at 15.
  function automatic logic [3:0] sat_count4(input logic [4:0] count);
    if (count > 5'd15) begin
      sat_count4 = 4'd15;
    end else begin
      sat_count4 = count[3:0];
    end
  endfunction

endpackage

// File: rtl/midi_tx_if.sv
// Wishbone-style register bus between a host (master) and a MIDI peripheral (slave).
interface midi_tx_if;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       stb;
  logic       we;
  logic       ack;

  modport master (output addr, output wdata, output stb, output we, input rdata, input ack);
  modport slave  (input addr, input wdata, input stb, input we, output rdata, output ack);
endinterface

// File: rtl/midi_fifo.sv
// Synchronous byte FIFO with occupancy count; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module midi_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign empty_o   = (count_q == {CW{1'b0}});
  assign full_o    = (count_q == CW'(DEPTH));
  assign count_o   = count_q;
  assign rdata_o   = mem_q[rptr_q];
  assign pop_ok_s  = pop_i && !empty_o;
  assign push_ok_s = push_i && (!full_o || pop_ok_s);

  // Pointer and occupancy next-state.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_ok_s) begin
      wptr_d = wptr_q + AW'(1'b1);
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_ok_s) begin
      rptr_d = rptr_q + AW'(1'b1);
    end else begin
      rptr_d = rptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CW'(1'b1);
      2'b01:   count_d = count_q - CW'(1'b1);
      default: count_d = count_q;
    endcase
  end

  // Storage and pointer registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wptr_q  <= {AW{1'b0}};
      rptr_q  <= {AW{1'b0}};
      count_q <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      if (push_ok_s) begin
        mem_q[wptr_q] <= wdata_i;
      end
    end
  end

endmodule

// File: rtl/midi_tx_wb.sv
// Register-bus slave for the MIDI transmitter: address decode, zero-wait
// acknowledge, STATUS read mux and TXDATA push strobe.
module midi_tx_wb
  import midi_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'h10
) (
  midi_tx_if.slave   bus,
  input  logic [7:0] status_i,
  output logic       push_o,
  output logic [7:0] push_data_o,
  output logic       status_rd_o
);
  logic hit_s;
  logic offset_s;

  assign hit_s       = bus.stb && (bus.addr[7:1] == BASE_ADDR[7:1]);
  assign offset_s    = bus.addr[0];
  assign bus.ack     = hit_s;
  assign push_data_o = bus.wdata;

  // Decode strobes and read data; TXDATA reads and misses return zero.
  always_comb begin
    bus.rdata   = 8'h00;
    push_o      = 1'b0;
    status_rd_o = 1'b0;
    if (hit_s && !bus.we && (offset_s == REG_STATUS)) begin
      bus.rdata   = status_i;
      status_rd_o = 1'b1;
    end else begin
      bus.rdata   = 8'h00;
      status_rd_o = 1'b0;
    end
    if (hit_s && bus.we && (offset_s == REG_TXDATA)) begin
      push_o = 1'b1;
    end else begin
      push_o = 1'b0;
    end
  end

endmodule

// File: rtl/midi_tx.sv
// MIDI serial transmitter: register-mapped byte FIFO feeding an 8N1 framer
// (start, 8 data bits LSB first, stop), CLKS_PER_BIT clocks per bit.
module midi_tx
  import midi_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 8,
  parameter int         FIFO_DEPTH   = 4,
  parameter logic [7:0] BASE_ADDR    = 8'h10
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_n_i,
  input  logic [7:0] wb_addr_i,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  input  logic       wb_stb_i,
  input  logic       wb_we_i,
  output logic       wb_ack_o,
  output logic       midi_out
);
  localparam int         CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [7:0] CNT_LAST = 8'(CLKS_PER_BIT - 1);

  midi_tx_if bus_if ();

  assign bus_if.addr  = wb_addr_i;
  assign bus_if.wdata = wb_dat_i;
  assign bus_if.stb   = wb_stb_i;
  assign bus_if.we    = wb_we_i;
  assign wb_dat_o     = bus_if.rdata;
  assign wb_ack_o     = bus_if.ack;

  midi_state_e   state_q, state_d;
  logic [7:0]    bit_cnt_q, bit_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          ovf_q, ovf_d;
  logic          midi_out_q, midi_out_d;
  logic          bit_end_s;
  logic          wr_push_s;
  logic [7:0]    wr_data_s;
  logic          status_rd_s;
  logic          fifo_pop_s;
  logic [7:0]    fifo_rdata_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic [CW-1:0] fifo_count_s;
  logic          rejected_s;
  logic [7:0]    status_s;

  midi_tx_wb #(.BASE_ADDR(BASE_ADDR)) u_wb (
    .bus         (bus_if.slave),
    .status_i    (status_s),
    .push_o      (wr_push_s),
    .push_data_o (wr_data_s),
    .status_rd_o (status_rd_s)
  );

  midi_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (wb_clk_i),
    .rst_n_i (wb_rst_n_i),
    .push_i  (wr_push_s),
    .pop_i   (fifo_pop_s),
    .wdata_i (wr_data_s),
    .rdata_o (fifo_rdata_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (fifo_count_s)
  );

  assign bit_end_s  = (bit_cnt_q == CNT_LAST);
  assign rejected_s = wr_push_s && fifo_full_s && !fifo_pop_s;
  assign midi_out   = midi_out_q;

  // STATUS register image.
  always_comb begin
    status_s                       = 8'h00;
    status_s[STAT_EMPTY]           = fifo_empty_s;
    status_s[STAT_FULL]            = fifo_full_s;
    status_s[STAT_BUSY]            = (state_q != ST_IDLE);
    status_s[STAT_OVF]             = ovf_q;
    status_s[STAT_CNT_LSB +: 4]    = sat_count4(5'(fifo_count_s));
  end

  // Sticky overflow: a rejected push wins over a clearing STATUS read.
  always_comb begin
    ovf_d = ovf_q;
    if (rejected_s) begin
      ovf_d = 1'b1;
    end else if (status_rd_s) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Framer next-state; STOP reloads straight into START so frames are gapless.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    fifo_pop_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bit_cnt_d = 8'd0;
        bit_idx_d = 3'd0;
        if (!fifo_empty_s) begin
          fifo_pop_s = 1'b1;
          shift_d    = fifo_rdata_s;
          state_d    = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          bit_cnt_d = 8'd0;
          bit_idx_d = 3'd0;
          state_d   = ST_DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + 8'd1;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          bit_cnt_d = 8'd0;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 8'd1;
        end
      end
      ST_STOP: begin
        if (bit_end_s) begin
          bit_cnt_d = 8'd0;
          bit_idx_d = 3'd0;
          if (!fifo_empty_s) begin
            fifo_pop_s = 1'b1;
            shift_d    = fifo_rdata_s;
            state_d    = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        bit_cnt_d = 8'd0;
        bit_idx_d = 3'd0;
      end
    endcase
  end

  // Line level follows the current state, so the output lags the state by one clock.
  always_comb begin
    midi_out_d = 1'b1;
    case (state_q)
      ST_IDLE:  midi_out_d = 1'b1;
      ST_START: midi_out_d = 1'b0;
      ST_DATA:  midi_out_d = shift_q[bit_idx_q];
      ST_STOP:  midi_out_d = 1'b1;
      default:  midi_out_d = 1'b1;
    endcase
  end

  // Framer, overflow and line registers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 8'd0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'h00;
      ovf_q      <= 1'b0;
      midi_out_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      ovf_q      <= ovf_d;
      midi_out_q <= midi_out_d;
    end
  end

endmodule

// File: tb/tb_midi_tx.sv
// Self-checking bench for midi_tx: register table, hand-written frame/FIFO
// corner sequences and randomized traffic against a timeline model of frames.
module tb_midi_tx;
  localparam int C     = 8;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * C;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic midi_out;
  always #5 clk = ~clk;

  midi_tx_if bus ();

  midi_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH), .BASE_ADDR(8'h10)) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .wb_addr_i  (bus.addr),
    .wb_dat_i   (bus.wdata),
    .wb_dat_o   (bus.rdata),
    .wb_stb_i   (bus.stb),
    .wb_we_i    (bus.we),
    .wb_ack_o   (bus.ack),
    .midi_out   (midi_out)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Model: each accepted byte becomes a frame occupying [start, start+FRAME) on the line.
  typedef struct { int push; int start; logic [7:0] b; } frame_t;
  frame_t frames[$];
  logic   m_ovf = 1'b0;

  typedef struct {
    logic       stb;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       exp_ack;
    logic [7:0] exp_dat;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic exp_line(input int t);
    for (int i = 0; i < frames.size(); i++) begin
      if (t >= frames[i].start && t < frames[i].start + FRAME) begin
        int k;
        k = (t - frames[i].start) / C;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return frames[i].b[k-1];
      end
    end
    return 1'b1;
  endfunction

  // Byte leaves the FIFO one edge before its start bit appears on the line.
  function automatic logic [7:0] exp_status(input int t);
    int cnt;
    logic busy;
    logic [3:0] c4;
    cnt  = 0;
    busy = 1'b0;
    for (int i = 0; i < frames.size(); i++) begin
      if (frames[i].push <= t && frames[i].start - 1 > t) cnt++;
      if (frames[i].start - 1 <= t && t < frames[i].start - 1 + FRAME) busy = 1'b1;
    end
    c4 = 4'((cnt > 15) ? 15 : cnt);
    return {c4, m_ovf, busy, (cnt == DEPTH), (cnt == 0)};
  endfunction

  task automatic model_push(input int n, input logic [7:0] b);
    int occ;
    int s;
    occ = 0;
    for (int i = 0; i < frames.size(); i++) begin
      if (frames[i].start - 1 > n) occ++;
    end
    if (occ >= DEPTH) begin
      m_ovf = 1'b1;
    end else begin
      s = n + 2;
      if (frames.size() > 0 && frames[$].start + FRAME > s) s = frames[$].start + FRAME;
      frames.push_back('{n, s, b});
    end
  endtask

  // Called on a falling edge; the push lands on the next rising edge.
  task automatic wb_write(input logic [7:0] addr, input logic [7:0] data);
    bus.stb   = 1'b1;
    bus.we    = 1'b1;
    bus.addr  = addr;
    bus.wdata = data;
    if (addr[7:1] == 7'h08 && addr[0] == 1'b1) model_push(cyc + 1, data);
    @(negedge clk);
    bus.stb = 1'b0;
    bus.we  = 1'b0;
  endtask

  task automatic read_status(input string name, output logic [7:0] v);
    bus.stb  = 1'b1;
    bus.we   = 1'b0;
    bus.addr = 8'h10;
    #1;
    v = bus.rdata;
    chk(name, v, exp_status(cyc));
    m_ovf = 1'b0;
    @(negedge clk);
    bus.stb = 1'b0;
  endtask

  task automatic line_at(input string name, input int t, input logic exp);
    while (cyc < t) @(negedge clk);
    chk(name, {7'd0, midi_out}, {7'd0, exp});
  endtask

  task automatic wait_drain();
    int lim;
    lim = (frames.size() > 0) ? frames[$].start + FRAME + 2 : cyc + 2;
    while (cyc < lim) @(negedge clk);
  endtask

  // Continuous line check against the frame timeline.
  always @(negedge clk) begin
    if (rst_n) chk("midi_out", {7'd0, midi_out}, {7'd0, exp_line(cyc)});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] st;
    logic [9:0] pat;
    int n0;

    bus.stb = 1'b0; bus.we = 1'b0; bus.addr = 8'h00; bus.wdata = 8'h00;
    vecs[0] = '{1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 8'h01};
    vecs[1] = '{1'b1, 1'b0, 8'h11, 8'h00, 1'b1, 8'h00};
    vecs[2] = '{1'b1, 1'b1, 8'h12, 8'h55, 1'b0, 8'h00};
    vecs[3] = '{1'b1, 1'b0, 8'h13, 8'h00, 1'b0, 8'h00};
    vecs[4] = '{1'b1, 1'b1, 8'h10, 8'hFF, 1'b1, 8'h00};
    vecs[5] = '{1'b0, 1'b0, 8'h10, 8'h00, 1'b0, 8'h00};
    vecs[6] = '{1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 8'h01};
    vecs[7] = '{1'b1, 1'b0, 8'h0F, 8'h00, 1'b0, 8'h00};

    // Reset state, observed while reset is still held.
    repeat (3) @(negedge clk);
    bus.stb = 1'b1; bus.addr = 8'h10; #1;
    chk("reset_status", bus.rdata, 8'h01);
    chk("reset_line", {7'd0, midi_out}, 8'h01);
    bus.stb = 1'b0;

    // Single byte pushed on the first edge after release.
    @(negedge clk);
    rst_n = 1'b1;
    n0 = cyc + 1;
    wb_write(8'h11, 8'hA5);
    read_status("a5_queued", st);
    chk("a5_queued_const", st, 8'h10);
    line_at("a5_pre_start", n0 + 1, 1'b1);
    pat = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 10; k++) begin
      line_at("a5_bit", n0 + 2 + k * C + C / 2, pat[k]);
      if (k == 0) begin
        read_status("a5_busy", st);
        chk("a5_busy_const", st, 8'h05);
      end
    end
    wait_drain();
    read_status("a5_done", st);
    chk("a5_done_const", st, 8'h01);

    // Register decode table.
    for (int i = 0; i < 8; i++) begin
      bus.stb = vecs[i].stb; bus.we = vecs[i].we;
      bus.addr = vecs[i].addr; bus.wdata = vecs[i].wdata;
      #1;
      chk($sformatf("vec%0d_ack", i), {7'd0, bus.ack}, {7'd0, vecs[i].exp_ack});
      if (!vecs[i].we) chk($sformatf("vec%0d_dat", i), bus.rdata, vecs[i].exp_dat);
      @(negedge clk);
      bus.stb = 1'b0; bus.we = 1'b0;
    end
    read_status("table_after", st);
    chk("table_after_const", st, 8'h01);

    // Back-to-back frames with no idle gap.
    n0 = cyc + 1;
    wb_write(8'h11, 8'h90);
    wb_write(8'h11, 8'h3C);
    wb_write(8'h11, 8'h7F);
    line_at("b2b_stop1", n0 + 2 + FRAME - 1, 1'b1);
    line_at("b2b_start2", n0 + 2 + FRAME, 1'b0);
    line_at("b2b_start3", n0 + 2 + 2 * FRAME, 1'b0);
    wait_drain();

    // Overflow: six pushes while one byte moves into the shifter.
    n0 = cyc + 1;
    for (int i = 1; i <= 6; i++) wb_write(8'h11, 8'(i));
    read_status("ovf_set", st);
    chk("ovf_set_const", st, 8'h4E);
    read_status("ovf_clr", st);
    chk("ovf_clr_const", st, 8'h46);

    // Push landing on the edge where STOP ends with a full FIFO.
    while (cyc < n0 + 2 + FRAME - 2) @(negedge clk);
    wb_write(8'h11, 8'hC3);
    read_status("full_pop", st);
    chk("full_pop_const", st, 8'h46);
    wait_drain();

    // Reset during data bit 3 aborts the frame and discards queued bytes.
    n0 = cyc + 1;
    wb_write(8'h11, 8'hF0);
    wb_write(8'h11, 8'h55);
    wb_write(8'h11, 8'hAA);
    line_at("pre_reset_low", n0 + 2 + 4 * C + 2, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_async_line", {7'd0, midi_out}, 8'h01);
    frames.delete();
    m_ovf = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    read_status("post_reset", st);
    chk("post_reset_const", st, 8'h01);
    repeat (20) @(negedge clk);

    // Randomized traffic, including occasional overflow.
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 120)) @(negedge clk);
      wb_write(8'h11, 8'($urandom));
      if ($urandom_range(0, 3) == 0) read_status("rand_status", st);
    end
    wait_drain();
    read_status("final_status", st);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
